// File: rtl/double_minmax_reduce.sv
// double_minmax_reduce: streaming max/min reducer over packets of binary64 values.
// Ordering key: sign ? ~bits : bits ^ sign_bit, compared unsigned. +0 and -0 tie.
// On a tie the earlier element is kept.
// Optional feature macro: DOUBLE_MINMAX_NAN_EN.
//   When defined, NaN elements set a sticky flag and do not take part in max/min.
//   They are still counted. A packet of only NaNs reports the canonical quiet NaN.
//   When undefined, NaNs are ordered by raw key and out_nan is tied low.
//
// state | meaning
// FIRST | waiting for first element of a packet
// ACCUM | folding further elements into max/min/count
// DONE  | result presented, input stalled until out_ready
module double_minmax_reduce #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      in_data,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [63:0]      out_max,
  output logic [63:0]      out_min,
  output logic [CNT_W-1:0] out_count,
  output logic             out_nan,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    FIRST = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [63:0]      SIGN_BIT = 64'h8000_0000_0000_0000;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  state_t           r_state;
  logic [63:0]      r_max;
  logic [63:0]      r_min;
  logic [CNT_W-1:0] r_count;
  logic             r_valid;

  logic [63:0]      w_in_key;
  logic [63:0]      w_max_key;
  logic [63:0]      w_min_key;
  logic             w_eq_max;
  logic             w_eq_min;
  logic             w_take_max;
  logic             w_take_min;
  logic             w_xfer;
  logic [CNT_W-1:0] w_cnt_next;

  // Map binary64 bits onto an unsigned key whose order matches numeric order.
  function automatic logic [63:0] f_key(input logic [63:0] b);
    return b[63] ? ~b : (b ^ SIGN_BIT);
  endfunction

  // Bitwise equality, except the two signed zeros are also treated as equal.
  function automatic logic f_same(input logic [63:0] a, input logic [63:0] b);
    return (a == b) || ((a[62:0] == 63'd0) && (b[62:0] == 63'd0));
  endfunction

  assign w_in_key   = f_key(in_data);
  assign w_max_key  = f_key(r_max);
  assign w_min_key  = f_key(r_min);
  assign w_eq_max   = f_same(in_data, r_max);
  assign w_eq_min   = f_same(in_data, r_min);
  // Strictly better only: ties keep the element already held.
  assign w_take_max = (w_in_key >= w_max_key) && !w_eq_max;
  assign w_take_min = (w_min_key >= w_in_key) && !w_eq_min;
  assign w_xfer     = in_valid && in_ready;
  assign w_cnt_next = (r_count == CNT_SAT) ? r_count : r_count + CNT_ONE;

  // Input is held off while in reset and while a result waits for downstream.
  assign in_ready  = rst_n && (r_state != DONE);
  assign out_max   = r_max;
  assign out_min   = r_min;
  assign out_count = r_count;
  assign out_valid = r_valid;

`ifdef DOUBLE_MINMAX_NAN_EN
  localparam logic [63:0] CANON_NAN = 64'h7FF8_0000_0000_0000;

  logic r_nan;
  logic r_have;
  logic w_in_nan;

  assign w_in_nan = (in_data[62:52] == 11'h7FF) && (in_data[51:0] != 52'd0);
  assign out_nan  = r_nan;

  // Packet FSM and result registers; r_have marks that a non-NaN value is held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= FIRST;
      r_max   <= '0;
      r_min   <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_nan   <= 1'b0;
      r_have  <= 1'b0;
    end else begin
      case (r_state)
        FIRST: begin
          if (w_xfer) begin
            r_count <= CNT_ONE;
            r_nan   <= w_in_nan;
            r_have  <= !w_in_nan;
            r_max   <= w_in_nan ? CANON_NAN : in_data;
            r_min   <= w_in_nan ? CANON_NAN : in_data;
            if (in_last) begin
              r_state <= DONE;
              r_valid <= 1'b1;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (w_xfer) begin
            r_count <= w_cnt_next;
            if (w_in_nan) begin
              r_nan <= 1'b1;
            end else if (!r_have) begin
              r_max  <= in_data;
              r_min  <= in_data;
              r_have <= 1'b1;
            end else begin
              if (w_take_max) r_max <= in_data;
              if (w_take_min) r_min <= in_data;
            end
            if (in_last) begin
              r_state <= DONE;
              r_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_state <= FIRST;
          end
        end
        default: r_state <= FIRST;
      endcase
    end
  end
`else
  assign out_nan = 1'b0;

  // Packet FSM and result registers; NaNs are ordered by their raw key.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= FIRST;
      r_max   <= '0;
      r_min   <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        FIRST: begin
          if (w_xfer) begin
            r_count <= CNT_ONE;
            r_max   <= in_data;
            r_min   <= in_data;
            if (in_last) begin
              r_state <= DONE;
              r_valid <= 1'b1;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (w_xfer) begin
            r_count <= w_cnt_next;
            if (w_take_max) r_max <= in_data;
            if (w_take_min) r_min <= in_data;
            if (in_last) begin
              r_state <= DONE;
              r_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_state <= FIRST;
          end
        end
        default: r_state <= FIRST;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_double_minmax_reduce.sv
// Bench for double_minmax_reduce: directed packets plus random packets checked
// against a real-valued reference model. A second instance with a 2-bit counter
// runs on the same stimulus to exercise count saturation.
module tb_double_minmax_reduce;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, in_ready2;
  logic [63:0] out_max, out_min, out_max2, out_min2;
  logic [15:0] out_count;
  logic [1:0]  out_count2;
  logic        out_nan, out_nan2, out_valid, out_valid2;

  int n_vec = 0;
  int n_err = 0;

  // values captured by run_pkt when a result appears
  logic [63:0] c_max, c_min, c_max2, c_min2;
  logic [15:0] c_cnt;
  logic [1:0]  c_cnt2;
  logic        c_nan, c_nan2, c_valid2;
  bit          c_lat_ok, c_stable_ok, c_ready_after, c_timeout;

  always #5 clk = ~clk;

  double_minmax_reduce dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .out_max(out_max),
    .out_min(out_min), .out_count(out_count), .out_nan(out_nan),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  double_minmax_reduce #(.CNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready2), .out_max(out_max2),
    .out_min(out_min2), .out_count(out_count2), .out_nan(out_nan2),
    .out_valid(out_valid2), .out_ready(out_ready)
  );

  // ---------------- reference model ----------------
  function automatic bit is_nan(input logic [63:0] b);
    return (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
  endfunction

  function automatic logic [63:0] okey(input logic [63:0] b);
    logic [63:0] s;
    s = 64'h8000_0000_0000_0000;
    return b[63] ? ~b : (b ^ s);
  endfunction

  // a strictly above b in the reducer's ordering
  function automatic bit above(input logic [63:0] a, input logic [63:0] b);
`ifndef DOUBLE_MINMAX_NAN_EN
    if (is_nan(a) || is_nan(b)) return okey(a) > okey(b);
`endif
    return $bitstoreal(a) > $bitstoreal(b);
  endfunction

  task automatic model(input logic [63:0] q[$], output logic [63:0] mx,
                       output logic [63:0] mn, output logic nan);
    bit have;
    have = 0; nan = 0; mx = '0; mn = '0;
    foreach (q[i]) begin
`ifdef DOUBLE_MINMAX_NAN_EN
      if (is_nan(q[i])) begin
        nan = 1;
        continue;
      end
`endif
      if (!have) begin
        mx = q[i]; mn = q[i]; have = 1;
      end else begin
        if (above(q[i], mx)) mx = q[i];
        if (above(mn, q[i])) mn = q[i];
      end
    end
    if (!have) begin
      mx = 64'h7FF8_0000_0000_0000;
      mn = 64'h7FF8_0000_0000_0000;
    end
  endtask

  function automatic logic [63:0] rand_elem();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    case ($urandom_range(0, 9))
      0: v = 64'h0000_0000_0000_0000;
      1: v = 64'h8000_0000_0000_0000;
      2: v = 64'h7FF0_0000_0000_0000;
      3: v = 64'hFFF0_0000_0000_0000;
      4: begin
        v[62:52] = 11'h7FF;
        if (v[51:0] == 52'd0) v[0] = 1'b1;
      end
      5: v = 64'h3FF0_0000_0000_0000;
      6: v = 64'hBFF0_0000_0000_0000;
      default: ;
    endcase
    return v;
  endfunction

  // ---------------- driver ----------------
  // Drive one packet back-to-back, capture the result, keep it pending for
  // 'hold' cycles with junk offered on the input, then hand it off.
  task automatic run_pkt(input logic [63:0] q[$], input int hold);
    int w;
    c_timeout = 0; c_stable_ok = 1;
    for (int i = 0; i < q.size(); i++) begin
      in_data = q[i]; in_last = (i == q.size() - 1); in_valid = 1'b1;
      w = 0;
      while (in_ready !== 1'b1 && w < 20) begin
        @(posedge clk); #1; w++;
      end
      if (in_ready !== 1'b1) c_timeout = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    c_lat_ok = (out_valid === 1'b1);
    w = 0;
    while (out_valid !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (out_valid !== 1'b1) c_timeout = 1;
    c_max = out_max; c_min = out_min; c_cnt = out_count; c_nan = out_nan;
    c_max2 = out_max2; c_min2 = out_min2; c_cnt2 = out_count2;
    c_nan2 = out_nan2; c_valid2 = out_valid2;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_last = 1'b1; in_data = {$urandom(), $urandom()};
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_max !== c_max ||
          out_min !== c_min || out_count !== c_cnt || out_nan !== c_nan)
        c_stable_ok = 0;
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    c_ready_after = (in_ready === 1'b1) && (out_valid === 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_in_ready got %b exp 0", in_ready);
    end
    n_vec++;
    if (out_valid !== 1'b0 || out_max !== 64'h0 || out_min !== 64'h0 ||
        out_count !== 16'd0 || out_nan !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs got v=%b max=%h min=%h cnt=%0d nan=%b exp all zero",
               out_valid, out_max, out_min, out_count, out_nan);
    end
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_in_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [63:0] q[$];
    q = '{64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 64'hC008_0000_0000_0000};
    run_pkt(q, 0);
    n_vec++;
    if (c_max !== 64'h4000_0000_0000_0000) begin
      n_err++; $display("FAIL basic_max got %h exp 4000000000000000", c_max);
    end
    n_vec++;
    if (c_min !== 64'hC008_0000_0000_0000) begin
      n_err++; $display("FAIL basic_min got %h exp c008000000000000", c_min);
    end
    n_vec++;
    if (c_cnt !== 16'd3) begin
      n_err++; $display("FAIL basic_count got %0d exp 3", c_cnt);
    end
    n_vec++;
    if (!c_lat_ok || c_timeout) begin
      n_err++; $display("FAIL basic_latency got lat_ok=%b timeout=%b exp 1/0", c_lat_ok, c_timeout);
    end
  endtask

  task automatic test_signed_zero();
    logic [63:0] q[$];
    q = '{64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000};
    run_pkt(q, 0);
    n_vec++;
    if (c_max !== 64'h0 || c_min !== 64'h0) begin
      n_err++; $display("FAIL zero_first_wins got max=%h min=%h exp 0/0", c_max, c_min);
    end
    q = '{64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000};
    run_pkt(q, 0);
    n_vec++;
    if (c_max !== 64'h8000_0000_0000_0000 || c_min !== 64'h8000_0000_0000_0000) begin
      n_err++; $display("FAIL negzero_first_wins got max=%h min=%h exp 8000000000000000 both", c_max, c_min);
    end
  endtask

  task automatic test_inf_hold();
    logic [63:0] q[$];
    q = '{64'h7FF0_0000_0000_0000};
    run_pkt(q, 5);
    n_vec++;
    if (c_max !== 64'h7FF0_0000_0000_0000 || c_min !== 64'h7FF0_0000_0000_0000) begin
      n_err++; $display("FAIL inf_single got max=%h min=%h exp 7ff0000000000000", c_max, c_min);
    end
    n_vec++;
    if (c_cnt !== 16'd1) begin
      n_err++; $display("FAIL inf_count got %0d exp 1", c_cnt);
    end
    n_vec++;
    if (!c_stable_ok) begin
      n_err++; $display("FAIL hold_stable got 0 exp 1");
    end
    n_vec++;
    if (!c_ready_after) begin
      n_err++; $display("FAIL ready_after_handoff got 0 exp 1");
    end
  endtask

  task automatic test_nan();
    logic [63:0] q[$];
    q = '{64'h3FF0_0000_0000_0000, 64'h7FF8_0000_0000_0001};
    run_pkt(q, 0);
`ifdef DOUBLE_MINMAX_NAN_EN
    n_vec++;
    if (c_max !== 64'h3FF0_0000_0000_0000 || c_min !== 64'h3FF0_0000_0000_0000 || c_nan !== 1'b1) begin
      n_err++; $display("FAIL nan_excluded got max=%h min=%h nan=%b exp 3ff0.. 3ff0.. 1", c_max, c_min, c_nan);
    end
    q = '{64'h7FF8_0000_0000_0001, 64'hFFF0_0000_0000_0123};
    run_pkt(q, 0);
    n_vec++;
    if (c_max !== 64'h7FF8_0000_0000_0000 || c_min !== 64'h7FF8_0000_0000_0000 || c_nan !== 1'b1) begin
      n_err++; $display("FAIL nan_all got max=%h min=%h nan=%b exp 7ff8000000000000 both, 1", c_max, c_min, c_nan);
    end
`else
    n_vec++;
    if (c_max !== 64'h7FF8_0000_0000_0001 || c_min !== 64'h3FF0_0000_0000_0000 || c_nan !== 1'b0) begin
      n_err++; $display("FAIL nan_raw_order got max=%h min=%h nan=%b exp 7ff8000000000001 3ff0000000000000 0", c_max, c_min, c_nan);
    end
`endif
    n_vec++;
    if (c_cnt !== 16'd2) begin
      n_err++; $display("FAIL nan_count got %0d exp 2", c_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] q[$];
    in_valid = 1'b1; in_last = 1'b0;
    in_data = 64'h3FF0_0000_0000_0000; @(posedge clk); #1;
    in_data = 64'hC000_0000_0000_0000; @(posedge clk); #1;
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_count !== 16'd0 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_mid got v=%b cnt=%0d rdy=%b exp 0 0 0", out_valid, out_count, in_ready);
    end
    rst_n = 1'b1;
    q = '{64'h4000_0000_0000_0000};
    run_pkt(q, 0);
    n_vec++;
    if (c_max !== 64'h4000_0000_0000_0000 || c_min !== 64'h4000_0000_0000_0000 || c_cnt !== 16'd1) begin
      n_err++; $display("FAIL restart got max=%h min=%h cnt=%0d exp 4000.. 4000.. 1", c_max, c_min, c_cnt);
    end
    // reset while a result is pending drops it
    in_valid = 1'b1; in_last = 1'b1; in_data = 64'h3FF0_0000_0000_0000;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_done_drop got v=%b rdy=%b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_saturate();
    logic [63:0] q[$];
    q = {};
    repeat (5) q.push_back(64'h3FF0_0000_0000_0000);
    run_pkt(q, 0);
    n_vec++;
    if (c_cnt2 !== 2'd3) begin
      n_err++; $display("FAIL sat_count got %0d exp 3", c_cnt2);
    end
    n_vec++;
    if (c_max2 !== 64'h3FF0_0000_0000_0000 || c_min2 !== 64'h3FF0_0000_0000_0000 ||
        c_nan2 !== 1'b0 || c_valid2 !== 1'b1 || in_ready2 !== 1'b1) begin
      n_err++; $display("FAIL sat_values got max=%h min=%h nan=%b v=%b rdy=%b exp 3ff0.. 3ff0.. 0 1 1",
                        c_max2, c_min2, c_nan2, c_valid2, in_ready2);
    end
    n_vec++;
    if (c_cnt !== 16'd5) begin
      n_err++; $display("FAIL wide_count got %0d exp 5", c_cnt);
    end
    // max/min keep moving after the narrow counter saturates
    q = '{64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000,
          64'h4010_0000_0000_0000, 64'hC010_0000_0000_0000};
    run_pkt(q, 0);
    n_vec++;
    if (c_cnt2 !== 2'd3 || c_max2 !== 64'h4010_0000_0000_0000 || c_min2 !== 64'hC010_0000_0000_0000) begin
      n_err++; $display("FAIL sat_update got cnt=%0d max=%h min=%h exp 3 4010.. c010..", c_cnt2, c_max2, c_min2);
    end
  endtask

  task automatic test_random();
    logic [63:0] q[$];
    logic [63:0] emx, emn;
    logic        enan;
    int          len, ecnt2;
    for (int p = 0; p < 30; p++) begin
      len = $urandom_range(1, 6);
      q = {};
      for (int i = 0; i < len; i++) q.push_back(rand_elem());
      model(q, emx, emn, enan);
      ecnt2 = (len > 3) ? 3 : len;
      run_pkt(q, $urandom_range(0, 2));
      n_vec++;
      if (c_max !== emx || c_min !== emn) begin
        n_err++; $display("FAIL rand_minmax pkt %0d got max=%h min=%h exp max=%h min=%h", p, c_max, c_min, emx, emn);
      end
      n_vec++;
      if (c_cnt !== 16'(len) || c_cnt2 !== 2'(ecnt2) || c_nan !== enan) begin
        n_err++; $display("FAIL rand_count pkt %0d got cnt=%0d cnt2=%0d nan=%b exp %0d %0d %b",
                          p, c_cnt, c_cnt2, c_nan, len, ecnt2, enan);
      end
      n_vec++;
      if (!c_lat_ok || c_timeout || !c_stable_ok || !c_ready_after) begin
        n_err++; $display("FAIL rand_handshake pkt %0d got lat=%b to=%b stable=%b rdy=%b exp 1 0 1 1",
                          p, c_lat_ok, c_timeout, c_stable_ok, c_ready_after);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] q[$];
    q = '{64'hC000_0000_0000_0000, 64'h4020_0000_0000_0000};
    run_pkt(q, 0);
    q = '{64'h3FE0_0000_0000_0000, 64'h3FD0_0000_0000_0000, 64'h3FF0_0000_0000_0000};
    run_pkt(q, 0);
    n_vec++;
    if (c_max !== 64'h3FF0_0000_0000_0000 || c_min !== 64'h3FD0_0000_0000_0000 || c_cnt !== 16'd3) begin
      n_err++; $display("FAIL b2b got max=%h min=%h cnt=%0d exp 3ff0.. 3fd0.. 3", c_max, c_min, c_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed_zero();
    test_inf_hold();
    test_nan();
    test_reset_mid();
    test_saturate();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
